// File: rtl/apb_ram_slave.sv
// rtl/apb_ram_slave.sv - APB3 completer with word-addressed RAM, parameterised wait states and pslverr on out-of-range addresses.
module apb_ram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  enter_ready;
  logic [ADDR_WIDTH-1:0] tgt_addr;
  logic                  tgt_write;
  logic                  tgt_err;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    prdata_d    = prdata_q;
    mem_d       = mem_q;
    enter_ready = 1'b0;
    // With zero wait states READY is entered on the setup edge itself, so use the live bus.
    tgt_addr    = (state_q == IDLE) ? paddr : addr_q;
    tgt_write   = (state_q == IDLE) ? pwrite : write_q;
    tgt_err     = (tgt_addr >= DEPTH_A);

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          cnt_d   = 4'd0;
          if (WAIT_STATES == 0) enter_ready = 1'b1;
          else                  state_d     = WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == WS_LAST) enter_ready = 1'b1;
        end
      end
      READY: begin
        if (!psel) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (penable) begin
          if (write_q && !tgt_err) mem_d[addr_q[IDX_W-1:0]] = pwdata;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_ready) begin
      state_d   = READY;
      pready_d  = 1'b1;
      pslverr_d = tgt_err;
      if (!tgt_write) prdata_d = tgt_err ? '0 : mem_q[tgt_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram_slave.sv
// tb/tb_apb_ram_slave.sv - Scoreboard bench for apb_ram_slave with three instances (0, 3 and 2 wait states).
module tb_apb_ram_slave;

  localparam int NDUT  = 3;
  localparam int DEPTH = 32;

  logic        pclk;
  logic        preset;
  logic        psel    [NDUT];
  logic        penable [NDUT];
  logic        pwrite  [NDUT];
  logic [31:0] paddr   [NDUT];
  logic [31:0] pwdata  [NDUT];
  logic [31:0] prdata  [NDUT];
  logic        pready  [NDUT];
  logic        pslverr [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_ram_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (DEPTH),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .pclk   (pclk),
      .preset (preset),
      .psel   (psel[g]),
      .penable(penable[g]),
      .pwrite (pwrite[g]),
      .paddr  (paddr[g]),
      .pwdata (pwdata[g]),
      .prdata (prdata[g]),
      .pready (pready[g]),
      .pslverr(pslverr[g])
    );
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_mem   [NDUT][DEPTH];
  logic [31:0] last_prdata [NDUT];
  int          tests  = 0;
  int          failed = 0;
  int          cyc    = 0;
  int          waitcnt [NDUT];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", name, d, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      last_prdata[d] = 32'h0;
      for (int a = 0; a < DEPTH; a++) model_mem[d][a] = 32'h0;
    end
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: pops one expectation per completed transfer and counts access cycles with pready low.
  always @(negedge pclk) begin : mon
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (psel[d] && penable[d]) begin
        if (pready[d]) begin
          if (sb.size() == 0) begin
            chk("unexpected_completion", d, 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("completion_dut", d, 32'(d), 32'(e.d));
            chk("pslverr", d, {31'd0, pslverr[d]}, {31'd0, e.err});
            chk("prdata", d, prdata[d], e.rdata);
            chk("wait_cycles", d, 32'(waitcnt[d]), 32'(e.waits));
          end
          waitcnt[d] = 0;
        end else begin
          waitcnt[d] = waitcnt[d] + 1;
        end
      end else begin
        if (pready[d]) chk("pready_outside_access", d, {31'd0, pready[d]}, 32'd0);
        waitcnt[d] = 0;
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the completion edge with the bus released.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    bit   done;
    e.d     = d;
    e.wr    = wr;
    e.addr  = addr;
    e.err   = (addr >= 32'(DEPTH));
    e.waits = ws_of(d);
    if (wr) begin
      e.rdata = last_prdata[d];
      if (!e.err) model_mem[d][addr[4:0]] = data;
    end else begin
      e.rdata = e.err ? 32'h0 : model_mem[d][addr[4:0]];
      last_prdata[d] = e.rdata;
    end
    sb.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    paddr[d]   = $urandom;
    pwrite[d]  = 1'($urandom);
    pwdata[d]  = $urandom;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge pclk);
      if (pready[d]) begin
        pwdata[d] = data;
        done = 1'b1;
      end else begin
        pwdata[d] = $urandom;
      end
      @(posedge pclk); #1;
    end
    if (!done) chk("xfer_timeout", d, 32'd0, 32'd1);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int d;
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;

    preset = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = 32'h0; pwdata[i] = 32'h0; waitcnt[i] = 0;
    end
    model_reset();
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_pready", i, {31'd0, pready[i]}, 32'd0);
      chk("reset_pslverr", i, {31'd0, pslverr[i]}, 32'd0);
      chk("reset_prdata", i, prdata[i], 32'd0);
    end

    apb_xfer(0, 1'b1, 32'd5, 32'hDEADBEEF);
    apb_xfer(0, 1'b0, 32'd5, 32'h0);
    apb_xfer(1, 1'b1, 32'd0, 32'h12345678);
    apb_xfer(1, 1'b0, 32'd0, 32'h0);
    apb_xfer(0, 1'b1, 32'd32, 32'hA5A5A5A5);
    apb_xfer(0, 1'b0, 32'd32, 32'h0);
    apb_xfer(0, 1'b0, 32'd0, 32'h0);

    c0 = cyc;
    for (int a = 0; a < 32; a++) apb_xfer(0, 1'b1, 32'(a), 32'(a * 3));
    for (int a = 0; a < 32; a++) apb_xfer(0, 1'b0, 32'(a), 32'h0);
    chk("b2b_cycles", 0, 32'(cyc - c0), 32'd128);

    // Abort during WAIT: drop psel after one access cycle.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'd3; pwdata[1] = 32'h1;
    @(posedge pclk); #1 penable[1] = 1'b1;
    @(posedge pclk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1;
    chk("abort_pready", 1, {31'd0, pready[1]}, 32'd0);
    apb_xfer(1, 1'b0, 32'd3, 32'h0);

    // Reset while dut2 is in WAIT of a write.
    apb_xfer(2, 1'b1, 32'd7, 32'h55);
    apb_xfer(2, 1'b0, 32'd7, 32'h0);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'd7; pwdata[2] = 32'hFFFF0000;
    @(posedge pclk); #1 penable[2] = 1'b1;
    @(posedge pclk); #1 preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
    model_reset();
    chk("rst_mid_pready", 2, {31'd0, pready[2]}, 32'd0);
    chk("rst_mid_pslverr", 2, {31'd0, pslverr[2]}, 32'd0);
    chk("rst_mid_prdata", 2, prdata[2], 32'd0);
    apb_xfer(2, 1'b0, 32'd7, 32'h0);

    for (int k = 0; k < 90; k++) begin
      d    = $urandom_range(0, NDUT - 1);
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(32, 40)) : 32'($urandom_range(0, 31));
      data = $urandom;
      apb_xfer(d, wr, addr, data);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge pclk); #1;
      end
    end

    repeat (3) @(posedge pclk);
    #1;
    chk("scoreboard_empty", 0, 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
